// File: rtl/moore_pkg.sv
// Shared constants and helpers for the Moore sequence counter.
package moore_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam int unsigned MAX_WIDTH = 16;

   // Callers zero-extend to MAX_WIDTH and truncate the result back to their width.
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/moore_seq_next.sv
// Combinational next-state for the sequence counter: count, Gray code and flags.
module moore_seq_next
   import moore_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             en,
   input  logic             dir,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next_cnt,
   output logic [WIDTH-1:0] next_gray,
   output logic             next_wrap,
   output logic             next_at_max,
   output logic             next_at_min
);

   localparam int unsigned   LastInt = MODULUS - 1;
   // One extra bit so MODULUS == 2**WIDTH compares without overflow.
   localparam logic [WIDTH:0]   Last    = (WIDTH+1)'(LastInt);
   localparam logic [WIDTH-1:0] LastCnt = WIDTH'(LastInt);

   logic at_last;
   logic at_zero;

   always_comb begin
      at_last   = ({1'b0, cnt} == Last);
      at_zero   = (cnt == '0);
      next_cnt  = cnt;
      next_wrap = 1'b0;
      if (load) begin
         next_cnt = ({1'b0, load_val} > Last) ? LastCnt : load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            if (!at_last) begin
               next_cnt = cnt + WIDTH'(1);
            end else if (sat_mode != MODE_SAT) begin
               next_cnt  = '0;
               next_wrap = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               next_cnt = cnt - WIDTH'(1);
            end else if (sat_mode != MODE_SAT) begin
               next_cnt  = LastCnt;
               next_wrap = 1'b1;
            end
         end
      end
      next_gray   = WIDTH'(bin2gray(MAX_WIDTH'(next_cnt)));
      next_at_max = ({1'b0, next_cnt} == Last);
      next_at_min = (next_cnt == '0);
   end

endmodule

// File: rtl/moore_seq_counter.sv
// Parametrised Moore sequence counter: register bank around moore_seq_next.
module moore_seq_counter
   import moore_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] gray,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap
);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (32'd1 << WIDTH))
   begin : gen_bad_params
      $error("moore_seq_counter: illegal WIDTH/MODULUS");
   end

   logic [WIDTH-1:0] cnt_d, cnt_q;
   logic [WIDTH-1:0] gray_d, gray_q;
   logic             at_max_d, at_max_q;
   logic             at_min_d, at_min_q;
   logic             wrap_d, wrap_q;

   moore_seq_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .cnt         (cnt_q),
      .en          (en),
      .dir         (dir),
      .sat_mode    (sat_mode),
      .load        (load),
      .load_val    (load_val),
      .next_cnt    (cnt_d),
      .next_gray   (gray_d),
      .next_wrap   (wrap_d),
      .next_at_max (at_max_d),
      .next_at_min (at_min_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         gray_q   <= '0;
         at_max_q <= 1'b0;
         at_min_q <= 1'b1;
         wrap_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         gray_q   <= gray_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
         wrap_q   <= wrap_d;
      end
   end

   assign cnt    = cnt_q;
   assign gray   = gray_q;
   assign at_max = at_max_q;
   assign at_min = at_min_q;
   assign wrap   = wrap_q;

endmodule
